// File: rtl/rf_pkg.sv
// Shared types and helpers for the bypassing integer register file.
//   XLEN_DEF   : default register width
//   rf_addr_w  : address width needed to index a register count
//   reg_addr_t : register address at the default register count
//   reg_data_t : register data at the default width
//   REG_ZERO   : address of the hardwired-zero register
package rf_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;

   function automatic int rf_addr_w(input int num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   localparam int ADDR_W_DEF = rf_addr_w(NUM_REGS_DEF);

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [XLEN_DEF-1:0]   reg_data_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters used by decode for hazard detection.
//   i_clk, i_rst          : clock, async active-high reset
//   i_en, i_rd            : writeback strobe and destination (retires a pending write)
//   i_issue_en, i_issue_rd: decode issues a producer for i_issue_rd
//   i_rs_address          : read-port addresses to report busy status for
//   o_rs_busy             : per read port, register still has an outstanding producer
//   o_issue_ready         : counter of i_issue_rd has room for another producer
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NUM_REGS = 32,
   parameter  int NUM_READ = 2,
   parameter  int PEND_W   = 2,
   localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_en,
   input  logic [ADDR_W-1:0]                 i_rd,
   input  logic                              i_issue_en,
   input  logic [ADDR_W-1:0]                 i_issue_rd,
   input  logic [NUM_READ-1:0][ADDR_W-1:0]   i_rs_address,
   output logic [NUM_READ-1:0]               o_rs_busy,
   output logic                              o_issue_ready
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0]   r_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;
   logic                w_issue_valid;
   logic                w_wr_valid;
   logic                w_issue_fire;

   assign w_issue_valid = (i_issue_rd != ADDR_W'(REG_ZERO)) && (32'(i_issue_rd) < NUM_REGS);
   assign w_wr_valid    = i_en && (i_rd != ADDR_W'(REG_ZERO)) && (32'(i_rd) < NUM_REGS);

   // Ready looks only at the registered count: a retire in the same cycle is not credited.
   assign o_issue_ready = !w_issue_valid || (r_cnt[i_issue_rd] != CNT_MAX);
   assign w_issue_fire  = i_issue_en && w_issue_valid && o_issue_ready;

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         w_inc[r] = w_issue_fire && (32'(i_issue_rd) == r);
         w_dec[r] = w_wr_valid && (32'(i_rd) == r) && (r_cnt[r] != '0);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (w_inc[r] && !w_dec[r]) begin
               r_cnt[r] <= r_cnt[r] + PEND_W'(1);
            end else if (w_dec[r] && !w_inc[r]) begin
               r_cnt[r] <= r_cnt[r] - PEND_W'(1);
            end
         end
      end
   end

   // A retiring write clears busy combinationally; a same-cycle issue does not raise it.
   always_comb begin
      o_rs_busy = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         if ((i_rs_address[p] != ADDR_W'(REG_ZERO)) && (32'(i_rs_address[p]) < NUM_REGS)) begin
            o_rs_busy[p] = (r_cnt[i_rs_address[p]] - PEND_W'(w_dec[i_rs_address[p]])) != '0;
         end
      end
   end

endmodule

// File: rtl/register_file_bypass.sv
// Integer register file with N combinational read ports, same-cycle
// write-to-read bypass, x0 hardwired to zero and a pending-write scoreboard.
//   i_clk, i_rst           : clock, async active-high reset
//   i_en, i_rd             : writeback write enable and destination
//   i_register_file_data   : writeback data
//   i_rs_address           : read addresses, one per port
//   o_rs_data              : read data, combinational
//   o_rs_busy              : read register has an outstanding producer
//   i_issue_en, i_issue_rd : decode issues an instruction writing i_issue_rd
//   o_issue_ready          : pending counter of i_issue_rd not saturated
module register_file_bypass
   import rf_pkg::*;
#(
   parameter  int XLEN     = XLEN_DEF,
   parameter  int NUM_REGS = 32,
   parameter  int NUM_READ = 2,
   parameter  int PEND_W   = 2,
   localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_en,
   input  logic [ADDR_W-1:0]                 i_rd,
   input  logic [XLEN-1:0]                   i_register_file_data,
   input  logic [NUM_READ-1:0][ADDR_W-1:0]   i_rs_address,
   output logic [NUM_READ-1:0][XLEN-1:0]     o_rs_data,
   output logic [NUM_READ-1:0]               o_rs_busy,
   input  logic                              i_issue_en,
   input  logic [ADDR_W-1:0]                 i_issue_rd,
   output logic                              o_issue_ready
);

   logic [XLEN-1:0] r_regs [NUM_REGS];
   logic            w_wr_valid;

   assign w_wr_valid = i_en && (i_rd != ADDR_W'(REG_ZERO)) && (32'(i_rd) < NUM_REGS);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_regs[r] <= '0;
         end
      end else if (w_wr_valid) begin
         r_regs[i_rd] <= i_register_file_data;
      end
   end

   // x0 and out-of-range addresses read zero and never see the bypass.
   always_comb begin
      o_rs_data = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         if ((i_rs_address[p] != ADDR_W'(REG_ZERO)) && (32'(i_rs_address[p]) < NUM_REGS)) begin
            if (i_en && (i_rd == i_rs_address[p])) begin
               o_rs_data[p] = i_register_file_data;
            end else begin
               o_rs_data[p] = r_regs[i_rs_address[p]];
            end
         end
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_READ (NUM_READ),
      .PEND_W   (PEND_W)
   ) u_scoreboard (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_en          (i_en),
      .i_rd          (i_rd),
      .i_issue_en    (i_issue_en),
      .i_issue_rd    (i_issue_rd),
      .i_rs_address  (i_rs_address),
      .o_rs_busy     (o_rs_busy),
      .o_issue_ready (o_issue_ready)
   );

endmodule

// File: tb/tb_register_file_bypass.sv
module tb_register_file_bypass;
   import rf_pkg::*;

   logic                  clk;
   logic                  rst;
   logic                  en;
   reg_addr_t             rd;
   reg_data_t             wdata;
   logic [1:0][4:0]       rs_address;
   logic [1:0][31:0]      rs_data;
   logic [1:0]            rs_busy;
   logic                  issue_en;
   reg_addr_t             issue_rd;
   logic                  issue_ready;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   register_file_bypass #(
      .XLEN     (32),
      .NUM_REGS (32),
      .NUM_READ (2),
      .PEND_W   (2)
   ) dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_en                 (en),
      .i_rd                 (rd),
      .i_register_file_data (wdata),
      .i_rs_address         (rs_address),
      .o_rs_data            (rs_data),
      .o_rs_busy            (rs_busy),
      .i_issue_en           (issue_en),
      .i_issue_rd           (issue_rd),
      .o_issue_ready        (issue_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [31:0] value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_underrun: observed %h with no expected value queued", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.value) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
         end
      end
   endtask

   // Advance to 1 time unit after the next rising edge, clear of the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      rd         = '0;
      wdata      = '0;
      rs_address = '0;
      issue_en   = 1'b0;
      issue_rd   = '0;

      // Reset state
      rs_address[0] = 5'd5;
      push("reset_data", 32'h0);
      push("reset_busy", 32'h0);
      push("reset_ready", 32'h1);
      #2;
      pop_check(rs_data[0]);
      pop_check({31'b0, rs_busy[0]});
      pop_check({31'b0, issue_ready});
      step();
      step();
      rst = 1'b0;

      // Basic write, visible through bypass, then from storage
      en = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
      push("write_bypass_p0", 32'hDEADBEEF);
      #1;
      pop_check(rs_data[0]);
      step();
      en = 1'b0; wdata = '0;
      push("write_stored_p0", 32'hDEADBEEF);
      #1;
      pop_check(rs_data[0]);

      // Second reset clears storage
      rst = 1'b1;
      push("rst2_clear", 32'h0);
      #1;
      pop_check(rs_data[0]);
      step();
      rst = 1'b0;

      // Bypass on port 1, port 0 still reading cleared reg 5
      en = 1'b1; rd = 5'd7; wdata = 32'h12345678; rs_address[1] = 5'd7;
      push("bypass_p1", 32'h12345678);
      push("bypass_p0_other", 32'h0);
      #1;
      pop_check(rs_data[1]);
      pop_check(rs_data[0]);
      step();
      en = 1'b0; wdata = '0;
      push("bypass_stored_p1", 32'h12345678);
      #1;
      pop_check(rs_data[1]);

      // x0 write discarded, both during the cycle and after
      en = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF; rs_address[0] = 5'd0;
      push("x0_bypass_masked", 32'h0);
      #1;
      pop_check(rs_data[0]);
      step();
      en = 1'b0;
      push("x0_after_write", 32'h0);
      #1;
      pop_check(rs_data[0]);

      // Issue to x0
      issue_en = 1'b1; issue_rd = 5'd0;
      push("x0_issue_ready", 32'h1);
      #1;
      pop_check({31'b0, issue_ready});
      step();
      issue_en = 1'b0;
      push("x0_busy", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});

      // Scoreboard: issue to x3
      rs_address[0] = 5'd3;
      issue_en = 1'b1; issue_rd = 5'd3;
      push("issue_same_cycle_busy", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});
      step();
      issue_en = 1'b0;
      push("issue_next_cycle_busy", 32'h1);
      #1;
      pop_check({31'b0, rs_busy[0]});

      // Write x3 clears busy in the write cycle
      en = 1'b1; rd = 5'd3; wdata = 32'h0000A5A5;
      push("retire_busy_comb", 32'h0);
      push("retire_data", 32'h0000A5A5);
      #1;
      pop_check({31'b0, rs_busy[0]});
      pop_check(rs_data[0]);
      step();
      en = 1'b0;
      push("retire_busy_after", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});

      // Simultaneous issue and write with cnt=1
      issue_en = 1'b1; issue_rd = 5'd3;
      step();
      en = 1'b1; rd = 5'd3; wdata = 32'h1;
      push("simul_busy_comb", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});
      step();
      issue_en = 1'b0; en = 1'b0;
      push("simul_cnt_stays_1", 32'h1);
      #1;
      pop_check({31'b0, rs_busy[0]});
      en = 1'b1;
      step();
      en = 1'b0;
      push("simul_then_retire", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});

      // Write with cnt=0 must not underflow the counter
      en = 1'b1; rd = 5'd3; wdata = 32'h77; rs_address[1] = 5'd3;
      push("idle_write_busy", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[1]});
      step();
      en = 1'b0; issue_rd = 5'd3;
      push("idle_write_no_underflow", 32'h1);
      push("idle_write_data", 32'h77);
      #1;
      pop_check({31'b0, issue_ready});
      pop_check(rs_data[1]);

      // Saturation on x9
      rs_address[0] = 5'd9;
      issue_en = 1'b1; issue_rd = 5'd9;
      step();
      push("sat_ready_cnt1", 32'h1);
      #1;
      pop_check({31'b0, issue_ready});
      step();
      push("sat_ready_cnt2", 32'h1);
      #1;
      pop_check({31'b0, issue_ready});
      step();
      push("sat_ready_cnt3", 32'h0);
      #1;
      pop_check({31'b0, issue_ready});
      step();   // fourth issue while not ready: ignored
      issue_en = 1'b0;
      en = 1'b1; rd = 5'd9; wdata = 32'h99;
      push("sat_decrement_not_credited", 32'h0);
      push("sat_busy_during_write", 32'h1);
      #1;
      pop_check({31'b0, issue_ready});
      pop_check({31'b0, rs_busy[0]});
      step();
      en = 1'b0;
      push("sat_ready_after_write", 32'h1);
      push("sat_busy_cnt2", 32'h1);
      #1;
      pop_check({31'b0, issue_ready});
      pop_check({31'b0, rs_busy[0]});
      en = 1'b1;
      step();
      push("sat_busy_cnt1_comb", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});
      step();
      en = 1'b0;
      push("sat_drained", 32'h0);
      #1;
      pop_check({31'b0, rs_busy[0]});

      // Async reset mid-burst: cnt[4]=2, regs[4]=0x55
      rs_address[0] = 5'd4;
      issue_en = 1'b1; issue_rd = 5'd4;
      step();
      step();
      step();
      issue_en = 1'b0;
      en = 1'b1; rd = 5'd4; wdata = 32'h55;
      step();
      en = 1'b0;
      push("pre_rst_data", 32'h55);
      push("pre_rst_busy", 32'h1);
      #1;
      pop_check(rs_data[0]);
      pop_check({31'b0, rs_busy[0]});
      issue_en = 1'b1; issue_rd = 5'd4; en = 1'b1; wdata = 32'hABCD;
      #1;
      rst = 1'b1;
      en = 1'b0;
      push("async_rst_data", 32'h0);
      push("async_rst_busy", 32'h0);
      push("async_rst_ready", 32'h1);
      #1;
      pop_check(rs_data[0]);
      pop_check({31'b0, rs_busy[0]});
      pop_check({31'b0, issue_ready});
      en = 1'b1;
      step();   // edge while rst high: write and issue blocked
      rst = 1'b0;
      en = 1'b0; issue_en = 1'b0;
      push("post_rst_data", 32'h0);
      push("post_rst_busy", 32'h0);
      #1;
      pop_check(rs_data[0]);
      pop_check({31'b0, rs_busy[0]});

      if (exp_q.size() != 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file_bypass.md
# register_file_bypass

Parametrised integer register file for the 5-stage pipelined RV32I core, replacing the single-cycle register file. It adds N read ports, same-cycle write-to-read bypass and asynchronous reset of all architectural state. It also carries a per-register pending-write scoreboard, which decode uses for hazard detection. It sits between decode (read and issue side) and writeback (write side).

## Interface
- XLEN, 32, data width of each register
- NUM_REGS, 32, number of architectural registers; x0 hardwired to zero
- NUM_READ, 2, number of independent read ports
- PEND_W, 2, width of each per-register pending-write counter
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  writeback write enable
- rd  in  ADDR_W  writeback destination register
- register_file_data  in  XLEN  writeback data
- rs_address  in  NUM_READ x ADDR_W  read addresses
- rs_data  out  NUM_READ x XLEN  read data, combinational
- rs_busy  out  NUM_READ  read register still has an outstanding producer
- issue_en  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of the issuing instruction
- issue_ready  out  1  pending counter of issue_rd is not saturated

## Operation
- **Write.** At posedge clk, if en and rd != 0, then regs[rd] <= register_file_data. A write with rd = 0 is discarded.
- **Read.** Each port is independent and combinational:
  - address 0 returns 0;
  - else, if en and rd == address, returns register_file_data (bypass);
  - else returns regs[address].
- **Scoreboard.** Each register r != 0 holds cnt[r], PEND_W bits, unsigned.
  - Increment when issue_en, issue_ready, issue_rd == r, r != 0.
  - Decrement when en, rd == r, cnt[r] != 0. A write when cnt[r] == 0 still updates data; the counter stays 0.
  - Increment and decrement in the same cycle on the same r: counter unchanged.
  - cnt[0] is constant 0.
- **rs_busy[p]** = (cnt[a] − hit) != 0, where a = rs_address[p] and hit = (en and rd == a and cnt[a] != 0).
  - A same-cycle issue does not affect rs_busy.
  - rs_busy is always 0 for address 0.
- **issue_ready** = (issue_rd == 0) or (cnt[issue_rd] != 2^PEND_W − 1).
  - A decrement landing in the same cycle is not credited.
  - issue_en while issue_ready is low is ignored; decode must stall.
- **Issue to x0** is ignored and issue_ready = 1.
- **Reset** (rst high, asynchronous): all regs = 0, all cnt = 0.
  - Resulting outputs: rs_data = 0, rs_busy = 0, issue_ready = 1.
  - Writes and issues are blocked while rst is high.

## Timing
- Write-to-register latency: 1 edge. The bypass makes the value visible on rs_data in the same cycle en is high.
- Issue-to-busy latency: 1 edge. rs_busy rises the cycle after the issue.
- Write-to-busy-clear: combinational in the write cycle, and the counter is updated at the edge.
- Read ports have no latency and no enable. All NUM_READ ports may address the same register.
- Reset mid-operation: asynchronous clear; in-flight issue and write are dropped; the first state update is at the first edge after rst deasserts.
- No X propagation: rs_address out of range (≥ NUM_REGS) reads 0, is not busy, and ignores writes and issues.

## Structure
- Package rf_pkg holds:
  - XLEN default;
  - the ADDR_W helper function;
  - typedef reg_addr_t (ADDR_W bits) and reg_data_t (XLEN bits);
  - constant REG_ZERO = 0.
- Sub-module rf_scoreboard holds the counter array, issue_ready and the rs_busy logic, parametrised by NUM_REGS, NUM_READ and PEND_W.
- The top level holds the storage array, the bypass muxes and the x0 masking.

## Test plan
- **Reset and basic write/read:** pulse rst, then en=1, rd=5, data=0xDEADBEEF; next cycle rs_address[0]=5 → rs_data[0]=0xDEADBEEF. After a second rst → 0.
- **Bypass:** en=1, rd=7, data=0x12345678 with rs_address[1]=7 in the same cycle → rs_data[1]=0x12345678 before the edge.
- **x0:**
  - en=1, rd=0, data=0xFFFFFFFF, then read 0 → 0.
  - issue_en=1, issue_rd=0 → issue_ready=1, rs_busy for address 0 stays 0.
- **Scoreboard:**
  - Issue rd=3 → rs_busy=1 next cycle.
  - Write rd=3 → rs_busy=0 in that cycle, counter returns to 0.
  - Simultaneous issue and write on rd=3 with cnt=1 → cnt stays 1, busy stays 1.
- **Saturation (PEND_W=2):** three issues to rd=9 → issue_ready=0. A fourth issue_en is ignored: after one write, cnt=2 and issue_ready=1.
- **Async reset mid-burst:** cnt[4]=2, regs[4]=0x55; assert rst between edges → rs_data=0, rs_busy=0 and issue_ready=1 immediately.
